mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be as follows; ports are then listed as name, direction, width, meaning (clock and reset first).
- DATA_WIDTH, default 32, data word width.
- ADDR_WIDTH, default 9, address width.
- MEM_DEPTH, default 512, number of valid words.
- RD_WAIT, default 2, cycles mem_read_enable is held per read; must be >=1.
- WR_WAIT, default 1, cycles mem_write_enable is held per write; must be >=1.
REQ-002 One clock and an asynchronous, active-low reset: clk in 1 system clock, rising edge; clr_n in 1 asynchronous active-low reset.
REQ-003 cpu_req in 1: access request, sampled on a rising clk edge.
REQ-004 cpu_we in 1: 1 = write, 0 = read; qualified by cpu_req.
REQ-005 cpu_addr in ADDR_WIDTH: word address.
REQ-006 cpu_wdata in DATA_WIDTH: write data.
REQ-007 cpu_busy out 1: controller not idle.
REQ-008 cpu_done out 1: one-cycle completion pulse.
REQ-009 cpu_err out 1: out-of-range address flag, valid with cpu_done.
REQ-010 cpu_rdata out DATA_WIDTH: last captured read word.
REQ-011 mem_addr out ADDR_WIDTH: address to the memory.
REQ-012 mem_data_in out DATA_WIDTH: write data to the memory.
REQ-013 mem_write_enable out 1: level-sensitive memory write strobe.
REQ-014 mem_read_enable out 1: level-sensitive memory read strobe.
REQ-015 mem_data_out in DATA_WIDTH: read data from the memory, asynchronous.

Function
REQ-016 The FSM SHALL have the states IDLE, RD_ACTIVE, WR_SETUP, WR_PULSE, WR_HOLD and DONE.
REQ-017 The controller SHALL accept a request only in IDLE with cpu_req=1.
- On acceptance it latches cpu_addr, cpu_wdata and cpu_we.
- Requests in any other state are ignored; there is no queue.
REQ-018 mem_addr and mem_data_in SHALL come only from the latched registers and SHALL stay stable from acceptance until the FSM returns to IDLE.
REQ-019 mem_read_enable, mem_write_enable, cpu_done and cpu_err SHALL be flop outputs, glitch-free, never combinational from the inputs.
REQ-020 Out-of-range address (latched addr >= MEM_DEPTH):
- IDLE goes directly to DONE with cpu_err=1.
- No enable is asserted and cpu_rdata is unchanged.
REQ-021 Read: IDLE goes to RD_ACTIVE.
- mem_read_enable=1 for exactly RD_WAIT cycles.
- On the last RD_ACTIVE edge, mem_data_out is captured into cpu_rdata, then the FSM goes to DONE.
- cpu_done is high in cycle RD_WAIT+1 after the acceptance edge.
REQ-022 Write: IDLE goes to WR_SETUP, which lasts 1 cycle with both enables 0.
- WR_PULSE follows: mem_write_enable=1 for exactly WR_WAIT cycles.
- WR_HOLD follows: 1 cycle, enables 0, address and data held.
- The FSM then goes to DONE; cpu_done is high in cycle WR_WAIT+3 after acceptance.
REQ-023 mem_write_enable and mem_read_enable SHALL never both be 1, and mem_write_enable SHALL never be 1 while mem_addr changes.
REQ-024 DONE SHALL last exactly 1 cycle (cpu_done=1), then go to IDLE; cpu_err is cleared on leaving DONE.
REQ-025 cpu_busy SHALL be 1 in every state except IDLE, combinational from the state register.
REQ-026 The wait counter SHALL be wide enough for max(RD_WAIT, WR_WAIT), reload on state entry, and never wrap.
REQ-027 cpu_rdata SHALL hold its value across writes, errors and idle cycles until the next successful read.

Reset
REQ-028 clr_n=0 SHALL immediately, without a clock, force:
- FSM to IDLE and wait counter to 0.
- mem_read_enable=0, mem_write_enable=0.
- cpu_done=0, cpu_err=0, cpu_busy=0.
- cpu_rdata=0, mem_addr=0, mem_data_in=0.
REQ-029 Reset asserted mid-access SHALL abort the access, including an in-progress write pulse, with no cpu_done.
REQ-030 After clr_n rises, the first request SHALL be accepted on the first rising edge where cpu_req=1.

Verification
REQ-031 Read, defaults, memory word 0x05 = 0xDEADBEEF:
- Stimulus: cpu_req=1, cpu_we=0, cpu_addr=0x05 for 1 cycle.
- Response: mem_read_enable high 2 cycles, cpu_done in cycle 3, cpu_rdata=0xDEADBEEF, cpu_err=0.
REQ-032 Write:
- Stimulus: cpu_we=1, cpu_addr=0x1FF, cpu_wdata=0x12345678.
- Response: 1 setup cycle, mem_write_enable high 1 cycle, 1 hold cycle, cpu_done in cycle 4.
- Follow-up: a read of 0x1FF returns 0x12345678.
REQ-033 Error, with MEM_DEPTH=256:
- Stimulus: read at 0x100.
- Response: cpu_done and cpu_err in cycle 1, no enable ever high, cpu_rdata unchanged.
REQ-034 Busy-ignore:
- Stimulus: a second cpu_req held through the first access and its DONE cycle.
- Response: only one access occurs; the second is accepted on the first IDLE edge after DONE.
REQ-035 Reset mid-write:
- Stimulus: clr_n low during WR_PULSE.
- Response: mem_write_enable drops asynchronously, all outputs 0, no cpu_done.
REQ-036 Back-to-back accesses:
- Stimulus: read then write with cpu_req held continuously.
- Response: enables never overlap, and mem_addr changes only while both enables are 0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory access controller: accepts one CPU read or write at a time and
// sequences the memory strobes. Reads hold mem_read_enable for RD_WAIT
// cycles. Writes wrap WR_WAIT write-strobe cycles with one setup cycle
// before and one hold cycle after. Addresses at or beyond MEM_DEPTH
// complete at once with cpu_err set.
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int MEM_DEPTH  = 512,
  parameter int RD_WAIT    = 2,
  parameter int WR_WAIT    = 1
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_busy,
  output logic                  cpu_done,
  output logic                  cpu_err,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  // The counter runs from WAIT-1 down to 0, so each strobe lasts exactly WAIT cycles.
  localparam logic [CNT_W-1:0]    RD_LOAD   = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0]    WR_LOAD   = CNT_W'(WR_WAIT - 1);
  // One extra bit lets MEM_DEPTH equal 2**ADDR_WIDTH without overflowing.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE, RD_ACTIVE, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic                    rd_en_reg, wr_en_reg, done_reg, err_reg;
  logic                    accept;
  logic                    addr_oor;
  logic                    capture;
  logic                    err_next;

  assign accept   = (state_reg == IDLE) && cpu_req;
  assign addr_oor = ({1'b0, cpu_addr} >= DEPTH_LIM);

  // Next-state and wait-counter logic. The access direction is held in the
  // state itself (RD_ACTIVE vs WR_*), so the latched cpu_we needs no separate
  // register.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cpu_req) begin
          cnt_next = '0;
          if (addr_oor) begin
            state_next = DONE;
          end else if (cpu_we) begin
            state_next = WR_SETUP;
          end else begin
            state_next = RD_ACTIVE;
            cnt_next   = RD_LOAD;
          end
        end
      end
      RD_ACTIVE: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      WR_SETUP: begin
        state_next = WR_PULSE;
        cnt_next   = WR_LOAD;
      end
      WR_PULSE: begin
        if (cnt_reg == '0) begin
          state_next = WR_HOLD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      WR_HOLD: state_next = DONE;
      DONE:    state_next = IDLE;
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Only the IDLE -> DONE shortcut is the out-of-range path.
  assign err_next = (state_reg == IDLE) && (state_next == DONE);

  // State, counter and registered strobes. The strobes are decoded from the
  // next state, so each one is a clean flop output that matches its state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rd_en_reg <= 1'b0;
      wr_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rd_en_reg <= (state_next == RD_ACTIVE);
      wr_en_reg <= (state_next == WR_PULSE);
      done_reg  <= (state_next == DONE);
      err_reg   <= err_next;
    end
  end

  // Latch the request on acceptance. Acceptance happens only in IDLE, so the
  // address and data stay fixed for the whole access.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      addr_reg  <= cpu_addr;
      wdata_reg <= cpu_wdata;
    end
  end

  // Capture read data on the final RD_ACTIVE edge. Otherwise hold the value.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rdata_reg <= '0;
    end else if (capture) begin
      rdata_reg <= mem_data_out;
    end
  end

  assign cpu_busy         = (state_reg != IDLE);
  assign cpu_done         = done_reg;
  assign cpu_err          = err_reg;
  assign cpu_rdata        = rdata_reg;
  assign mem_addr         = addr_reg;
  assign mem_data_in      = wdata_reg;
  assign mem_write_enable = wr_en_reg;
  assign mem_read_enable  = rd_en_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl. The main instance uses the default
// parameters and drives a behavioural memory. A second instance uses
// MEM_DEPTH=256 and shares the request inputs; it exercises the
// out-of-range path.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        clr_n = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [8:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;

  logic        cpu_busy, cpu_done, cpu_err;
  logic [31:0] cpu_rdata, mem_data_in, mem_data_out;
  logic [8:0]  mem_addr;
  logic        mem_write_enable, mem_read_enable;

  logic        e_busy, e_done, e_err;
  logic [31:0] e_rdata, e_mem_data_in;
  logic [31:0] e_mem_data_out = 32'hCAFE0001;
  logic [8:0]  e_mem_addr;
  logic        e_we, e_re;

  logic [31:0] mem [0:511];
  logic        mem_loaded = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          done_count = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .clr_n(clr_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy),
    .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_data_out(mem_data_out)
  );

  mem_access_ctrl #(.MEM_DEPTH(256)) dut_err (
    .clk(clk), .clr_n(clr_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(e_busy),
    .cpu_done(e_done), .cpu_err(e_err), .cpu_rdata(e_rdata),
    .mem_addr(e_mem_addr), .mem_data_in(e_mem_data_in),
    .mem_write_enable(e_we), .mem_read_enable(e_re),
    .mem_data_out(e_mem_data_out)
  );

  // Behavioural memory: asynchronous read, write on each clock while strobed.
  assign mem_data_out = mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem[5] <= 32'hDEADBEEF;
      mem_loaded <= 1'b1;
    end else if (mem_write_enable) begin
      mem[mem_addr] <= mem_data_in;
    end
  end

  always @(posedge clk) if (cpu_done) done_count <= done_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 clr_n = 1'b0;
    repeat (3) tick();
    checks += 8;
    if (cpu_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", cpu_busy); end
    if (cpu_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", cpu_done); end
    if (cpu_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", cpu_err); end
    if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
    if (mem_addr !== 9'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    if (mem_data_in !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", mem_data_in); end
    if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL rst_re: got %0b want 0", mem_read_enable); end
    if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", mem_write_enable); end
    $display("reset: outputs checked, releasing clr_n");
    clr_n = 1'b1;
  endtask

  // Read 0x05 issued right after reset release: must be taken on the first edge.
  task automatic test_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
    tick();
    cpu_req = 1'b0;
    checks += 4;
    if (mem_read_enable !== 1'b1) begin errors++; $display("FAIL rd_c1_re: got %0b want 1", mem_read_enable); end
    if (cpu_busy !== 1'b1) begin errors++; $display("FAIL rd_c1_busy: got %0b want 1", cpu_busy); end
    if (cpu_done !== 1'b0) begin errors++; $display("FAIL rd_c1_done: got %0b want 0", cpu_done); end
    if (mem_addr !== 9'h005) begin errors++; $display("FAIL rd_c1_addr: got %h want 005", mem_addr); end
    tick();
    checks += 2;
    if (mem_read_enable !== 1'b1) begin errors++; $display("FAIL rd_c2_re: got %0b want 1", mem_read_enable); end
    if (cpu_done !== 1'b0) begin errors++; $display("FAIL rd_c2_done: got %0b want 0", cpu_done); end
    tick();
    checks += 4;
    if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL rd_c3_re: got %0b want 0", mem_read_enable); end
    if (cpu_done !== 1'b1) begin errors++; $display("FAIL rd_c3_done: got %0b want 1", cpu_done); end
    if (cpu_err !== 1'b0) begin errors++; $display("FAIL rd_c3_err: got %0b want 0", cpu_err); end
    if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_c3_rdata: got %h want deadbeef", cpu_rdata); end
    tick();
    checks += 2;
    if (cpu_done !== 1'b0) begin errors++; $display("FAIL rd_c4_done: got %0b want 0", cpu_done); end
    if (cpu_busy !== 1'b0) begin errors++; $display("FAIL rd_c4_busy: got %0b want 0", cpu_busy); end
    $display("read addr=005 rdata=%h", cpu_rdata);
  endtask

  task automatic test_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h1FF; cpu_wdata = 32'h12345678;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 9'h000; cpu_wdata = 32'h0;
    checks += 4;
    if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL wr_setup_we: got %0b want 0", mem_write_enable); end
    if (cpu_busy !== 1'b1) begin errors++; $display("FAIL wr_setup_busy: got %0b want 1", cpu_busy); end
    if (mem_addr !== 9'h1FF) begin errors++; $display("FAIL wr_setup_addr: got %h want 1ff", mem_addr); end
    if (mem_data_in !== 32'h12345678) begin errors++; $display("FAIL wr_setup_data: got %h want 12345678", mem_data_in); end
    tick();
    checks += 2;
    if (mem_write_enable !== 1'b1) begin errors++; $display("FAIL wr_pulse_we: got %0b want 1", mem_write_enable); end
    if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL wr_pulse_re: got %0b want 0", mem_read_enable); end
    tick();
    checks += 3;
    if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL wr_hold_we: got %0b want 0", mem_write_enable); end
    if (cpu_done !== 1'b0) begin errors++; $display("FAIL wr_hold_done: got %0b want 0", cpu_done); end
    if (mem_data_in !== 32'h12345678) begin errors++; $display("FAIL wr_hold_data: got %h want 12345678", mem_data_in); end
    tick();
    checks += 3;
    if (cpu_done !== 1'b1) begin errors++; $display("FAIL wr_c4_done: got %0b want 1", cpu_done); end
    if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rdata_held: got %h want deadbeef", cpu_rdata); end
    if (mem[9'h1FF] !== 32'h12345678) begin errors++; $display("FAIL wr_mem: got %h want 12345678", mem[9'h1FF]); end
    $display("write addr=1ff wdata=12345678");
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h1FF;
    tick();
    cpu_req = 1'b0;
    tick();
    tick();
    checks += 2;
    if (cpu_done !== 1'b1) begin errors++; $display("FAIL rdbk_done: got %0b want 1", cpu_done); end
    if (cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL rdbk_rdata: got %h want 12345678", cpu_rdata); end
    $display("read addr=1ff rdata=%h", cpu_rdata);
    tick();
  endtask

  // The MEM_DEPTH=256 instance last read 0x05 successfully, capturing its
  // constant memory word 0xCAFE0001. Its 0x1FF accesses were errors.
  task automatic test_error();
    checks += 1;
    if (e_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL err_pre_rdata: got %h want cafe0001", e_rdata); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h100;
    tick();
    cpu_req = 1'b0;
    checks += 4;
    if (e_done !== 1'b1) begin errors++; $display("FAIL err_done: got %0b want 1", e_done); end
    if (e_err !== 1'b1) begin errors++; $display("FAIL err_flag: got %0b want 1", e_err); end
    if (e_re !== 1'b0) begin errors++; $display("FAIL err_re: got %0b want 0", e_re); end
    if (e_we !== 1'b0) begin errors++; $display("FAIL err_we: got %0b want 0", e_we); end
    tick();
    checks += 4;
    if (e_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b want 0", e_err); end
    if (e_busy !== 1'b0) begin errors++; $display("FAIL err_busy: got %0b want 0", e_busy); end
    if (e_re !== 1'b0) begin errors++; $display("FAIL err_re2: got %0b want 0", e_re); end
    if (e_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL err_rdata: got %h want cafe0001", e_rdata); end
    $display("read addr=100 (depth 256) err=1 rdata=%h", e_rdata);
    repeat (3) tick();
  endtask

  task automatic test_busy_ignore();
    int start_cnt;
    start_cnt = done_count;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
    tick(); tick(); tick();
    checks += 1;
    if (cpu_done !== 1'b1) begin errors++; $display("FAIL bi_done1: got %0b want 1", cpu_done); end
    tick();
    checks += 1;
    if (cpu_busy !== 1'b0) begin errors++; $display("FAIL bi_idle: got %0b want 0", cpu_busy); end
    tick();
    cpu_req = 1'b0;
    checks += 1;
    if (mem_read_enable !== 1'b1) begin errors++; $display("FAIL bi_accept2: got %0b want 1", mem_read_enable); end
    repeat (4) tick();
    checks += 1;
    if (done_count - start_cnt !== 2) begin errors++; $display("FAIL bi_count: got %0d want 2", done_count - start_cnt); end
    $display("busy-ignore: held request served as %0d accesses", done_count - start_cnt);
  endtask

  task automatic test_back_to_back();
    logic [8:0] prev_addr;
    logic       prev_re, prev_we;
    int         start_cnt;
    start_cnt = done_count;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      prev_addr = mem_addr; prev_re = mem_read_enable; prev_we = mem_write_enable;
      tick();
      checks += 2;
      if (mem_read_enable && mem_write_enable) begin errors++; $display("FAIL b2b_overlap c%0d: re=1 we=1 want not both", cyc); end
      if ((mem_addr !== prev_addr) && (prev_re || prev_we || mem_read_enable || mem_write_enable)) begin
        errors++; $display("FAIL b2b_addr c%0d: addr %h->%h with enable high", cyc, prev_addr, mem_addr);
      end
      if (cyc == 1) begin cpu_we = 1'b1; cpu_addr = 9'h010; cpu_wdata = 32'hA5A50F0F; end
      if (cyc == 6) begin
        checks += 1;
        if (mem_write_enable !== 1'b1) begin errors++; $display("FAIL b2b_we: got %0b want 1", mem_write_enable); end
      end
      if (cyc == 8) begin
        checks += 1;
        if (cpu_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %0b want 1", cpu_done); end
        cpu_req = 1'b0; cpu_we = 1'b0;
      end
    end
    checks += 3;
    if (mem[9'h010] !== 32'hA5A50F0F) begin errors++; $display("FAIL b2b_mem: got %h want a5a50f0f", mem[9'h010]); end
    if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata: got %h want deadbeef", cpu_rdata); end
    if (done_count - start_cnt !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", done_count - start_cnt); end
    $display("back-to-back: read 005 then write 010=a5a50f0f");
  endtask

  task automatic test_reset_mid_write();
    int start_cnt;
    start_cnt = done_count;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h020; cpu_wdata = 32'h55AA55AA;
    tick();
    cpu_req = 1'b0;
    tick();
    checks += 1;
    if (mem_write_enable !== 1'b1) begin errors++; $display("FAIL rmw_pulse: got %0b want 1", mem_write_enable); end
    #2 clr_n = 1'b0;
    #1;
    checks += 7;
    if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL rmw_we: got %0b want 0", mem_write_enable); end
    if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL rmw_re: got %0b want 0", mem_read_enable); end
    if (cpu_busy !== 1'b0) begin errors++; $display("FAIL rmw_busy: got %0b want 0", cpu_busy); end
    if (cpu_done !== 1'b0) begin errors++; $display("FAIL rmw_done: got %0b want 0", cpu_done); end
    if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rmw_rdata: got %h want 0", cpu_rdata); end
    if (mem_addr !== 9'h0) begin errors++; $display("FAIL rmw_addr: got %h want 0", mem_addr); end
    if (mem_data_in !== 32'h0) begin errors++; $display("FAIL rmw_data: got %h want 0", mem_data_in); end
    repeat (2) tick();
    clr_n = 1'b1;
    repeat (3) tick();
    checks += 2;
    if (done_count !== start_cnt) begin errors++; $display("FAIL rmw_nodone: got %0d want %0d", done_count, start_cnt); end
    if (mem[9'h020] !== 32'h0) begin errors++; $display("FAIL rmw_mem: got %h want 0", mem[9'h020]); end
    $display("reset mid-write addr=020: access aborted");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_error();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
